// File: rtl/vars_states_loader.sv
// rtl/vars_states_loader.sv - moves per-variable state words between BRAM and the engine load/update port
// Optional VARS_LOADER_BURST_WR_EN: strobe all engine banks together once the load vector is complete.
module vars_states_loader #(
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_VAR_STATES = 17,
  parameter int ADDR_WIDTH       = 9
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_load_i,
  input  logic                                 start_store_i,
  input  logic [ADDR_WIDTH-1:0]                base_addr_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]                mem_rd_addr_o,
  input  logic [WIDTH_VAR_STATES-1:0]          mem_rd_data_i,
  output logic                                 mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]                mem_wr_addr_o,
  output logic [WIDTH_VAR_STATES-1:0]          mem_wr_data_o,
  output logic [NUM_VARS-1:0]                  wr_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i
);

  localparam int W  = WIDTH_VAR_STATES;
  localparam int CW = (NUM_VARS > 2) ? $clog2(NUM_VARS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOAD_DRAIN, S_STORE, S_DONE
  } state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [W-1:0]          r_slots [NUM_VARS];
  logic [W-1:0]          r_snap  [NUM_VARS];
  logic                  r_rd_vld;
  logic [CW-1:0]         r_rd_idx;
  logic [NUM_VARS-1:0]   r_wr_states;
  logic [ADDR_WIDTH-1:0] w_addr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_load_i)       w_next = S_LOAD;
        else if (start_store_i) w_next = S_STORE;
      end
      S_LOAD:       if (r_cnt == CW'(NUM_VARS - 1)) w_next = S_LOAD_DRAIN;
      S_LOAD_DRAIN: if (r_cnt == CW'(1))            w_next = S_DONE;
      S_STORE:      if (r_cnt == CW'(NUM_VARS - 1)) w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

`ifndef VARS_LOADER_BURST_WR_EN
  logic [NUM_VARS-1:0] w_onehot;
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_VARS; k++)
      w_onehot[NUM_VARS-1-k] = r_rd_vld && (r_rd_idx == CW'(k));
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_idx    <= '0;
      r_wr_states <= '0;
      for (int k = 0; k < NUM_VARS; k++) begin
        r_slots[k] <= '0;
        r_snap[k]  <= '0;
      end
    end else begin
      r_state <= w_next;
      // r_cnt restarts on every state change; it indexes the word within LOAD/STORE and times the drain
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      if (r_state == S_IDLE && w_next != S_IDLE)
        r_base <= base_addr_i;
      if (r_state == S_IDLE && w_next == S_STORE)
        for (int k = 0; k < NUM_VARS; k++)
          r_snap[k] <= vars_states_i[W*(NUM_VARS-k)-1 -: W];
      // BRAM returns data one cycle after the strobe; track which slot it belongs to
      r_rd_vld <= (r_state == S_LOAD);
      r_rd_idx <= r_cnt;
      if (r_rd_vld)
        r_slots[r_rd_idx] <= mem_rd_data_i;
`ifdef VARS_LOADER_BURST_WR_EN
      r_wr_states <= (r_rd_vld && r_rd_idx == CW'(NUM_VARS - 1)) ? '1 : '0;
`else
      r_wr_states <= w_onehot;
`endif
    end
  end

  assign w_addr = r_base + ADDR_WIDTH'(r_cnt);

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign mem_rd_en_o   = (r_state == S_LOAD);
  assign mem_rd_addr_o = w_addr;
  assign mem_wr_en_o   = (r_state == S_STORE);
  assign mem_wr_addr_o = w_addr;
  assign mem_wr_data_o = r_snap[r_cnt];
  assign wr_states_o   = r_wr_states;

  for (genvar k = 0; k < NUM_VARS; k++) begin : g_pack
    assign vars_states_o[W*(NUM_VARS-k)-1 -: W] = r_slots[k];
  end

endmodule

// File: tb/tb_vars_states_loader.sv
// tb/tb_vars_states_loader.sv - scoreboard bench for vars_states_loader
module tb_vars_states_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_load_i = 1'b0;
  logic         start_store_i = 1'b0;
  logic [8:0]   base_addr_i = '0;
  logic         busy_o, done_o, mem_rd_en_o, mem_wr_en_o;
  logic [8:0]   mem_rd_addr_o, mem_wr_addr_o;
  logic [16:0]  mem_rd_data_i;
  logic [16:0]  mem_wr_data_o;
  logic [7:0]   wr_states_o;
  logic [135:0] vars_states_o, vars_states_i;
  logic [135:0] eng_vec = '0;
  logic         echo = 1'b0;

  assign vars_states_i = echo ? vars_states_o : eng_vec;

  vars_states_loader #(.NUM_VARS(8), .WIDTH_VAR_STATES(17), .ADDR_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .start_load_i(start_load_i), .start_store_i(start_store_i),
    .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .wr_states_o(wr_states_o), .vars_states_o(vars_states_o), .vars_states_i(vars_states_i)
  );

  always #5 clk = ~clk;

  logic [16:0] mem [512];
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];
    if (mem_wr_en_o) mem[mem_wr_addr_o] <= mem_wr_data_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
  endtask

  typedef struct { int cyc; logic [8:0] addr; logic [16:0] data; } mem_ev_t;
  typedef struct { int cyc; logic [7:0] st; logic [135:0] vec; } st_ev_t;
  mem_ev_t rdq[$];
  mem_ev_t wrq[$];
  st_ev_t  stq[$];
  int      doneq[$];
  int      donelog[$];

  task automatic push_mem(input bit wr, input int c, input logic [8:0] a, input logic [16:0] d);
    mem_ev_t e;
    e.cyc = c; e.addr = a; e.data = d;
    if (wr) wrq.push_back(e); else rdq.push_back(e);
  endtask

  task automatic push_st(input int c, input logic [7:0] st, input logic [135:0] vec);
    st_ev_t e;
    e.cyc = c; e.st = st; e.vec = vec;
    stq.push_back(e);
  endtask

  function automatic logic [135:0] pack8(input logic [16:0] s [8]);
    logic [135:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[17*(8-k)-1 -: 17] = s[k];
    return v;
  endfunction

  // Monitor: every DUT-side event must match the head of its expectation queue.
  always @(negedge clk) begin
    mem_ev_t e;
    st_ev_t  s;
    if (mem_rd_en_o) begin
      if (rdq.size() == 0) unexpected("rd_event");
      else begin
        e = rdq.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("rd_addr", mem_rd_addr_o, e.addr);
      end
    end
    if (mem_wr_en_o) begin
      if (wrq.size() == 0) unexpected("wr_event");
      else begin
        e = wrq.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", mem_wr_addr_o, e.addr);
        check("wr_data", mem_wr_data_o, e.data);
      end
    end
    if (wr_states_o != 8'h00) begin
      if (stq.size() == 0) unexpected("wr_states_event");
      else begin
        s = stq.pop_front();
        check("wr_states_cycle", cyc, s.cyc);
        check("wr_states_value", wr_states_o, s.st);
        check("wr_states_vector", vars_states_o, s.vec);
      end
    end
    if (done_o) begin
      donelog.push_back(cyc);
      if (doneq.size() == 0) unexpected("done_event");
      else check("done_cycle", cyc, doneq.pop_front());
    end
  end

  logic [16:0] exp_slots [8];

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_rd_en"}, mem_rd_en_o, 0);
    check({tag, "_wr_en"}, mem_wr_en_o, 0);
    check({tag, "_wr_states"}, wr_states_o, 0);
    check({tag, "_vars"}, vars_states_o, 0);
    check({tag, "_rd_addr"}, mem_rd_addr_o, 0);
    check({tag, "_wr_addr"}, mem_wr_addr_o, 0);
  endtask

  // rst_at != 0 pulls reset low in that cycle of the transfer.
  task automatic do_load(input logic [8:0] base, input bit both, input bit poke, input int rst_at);
    logic [16:0] newv [8];
    logic [16:0] s [8];
    int t0, lim;
    lim = (rst_at == 0) ? 99 : rst_at;
    @(negedge clk);
    t0 = cyc;
    base_addr_i = base;
    start_load_i = 1'b1;
    start_store_i = both;
    for (int j = 0; j < 8; j++) newv[j] = mem[base + 9'(j)];
    for (int k = 0; k < 8; k++) begin
      if (k + 1 <= lim) push_mem(1'b0, t0 + k + 1, base + 9'(k), '0);
`ifndef VARS_LOADER_BURST_WR_EN
      if (k + 3 <= lim) begin
        for (int j = 0; j < 8; j++) s[j] = (j <= k) ? newv[j] : exp_slots[j];
        push_st(t0 + k + 3, 8'h80 >> k, pack8(s));
      end
`endif
    end
`ifdef VARS_LOADER_BURST_WR_EN
    if (10 <= lim) push_st(t0 + 10, 8'hFF, pack8(newv));
`endif
    if (11 <= lim) doneq.push_back(t0 + 11);
    for (int j = 0; j < 8; j++) exp_slots[j] = (rst_at == 0) ? newv[j] : 17'h0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start_load_i = 1'b0;
      start_store_i = poke && (c == 5 || c == 11);
      if (c == rst_at) rst = 1'b0;
      if (rst_at != 0 && c == rst_at + 1) begin
        rst = 1'b1;
        check_quiet("after_reset");
      end
    end
    check("idle_after_load", busy_o, 0);
  endtask

  task automatic do_store(input logic [8:0] base, input logic [135:0] exp_vec, input int change_at);
    int t0;
    @(negedge clk);
    t0 = cyc;
    base_addr_i = base;
    start_store_i = 1'b1;
    for (int k = 0; k < 8; k++)
      push_mem(1'b1, t0 + k + 1, base + 9'(k), exp_vec[17*(8-k)-1 -: 17]);
    doneq.push_back(t0 + 9);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_store_i = 1'b0;
      if (c == change_at) eng_vec = ~eng_vec;
    end
    check("idle_after_store", busy_o, 0);
  endtask

  logic [135:0] v;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 17'h0;
    for (int k = 0; k < 8; k++) begin
      mem[9'h010 + 9'(k)] = 17'h100 + 17'(k);
      mem[9'h040 + 9'(k)] = 17'h155 + 17'(k);
      mem[9'h080 + 9'(k)] = 17'h15000 + 17'(k * 'h123);
      exp_slots[k] = 17'h0;
    end
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // load from 0x10
    do_load(9'h010, 1'b0, 1'b0, 0);
    check("load_vector", vars_states_o, pack8(exp_slots));

    // store across the top of the address space, engine input changes in cycle 2
    for (int k = 0; k < 8; k++) v[17*(8-k)-1 -: 17] = 17'h0A0 + 17'(k);
    eng_vec = v;
    do_store(9'h1FC, v, 2);
    check("store_keeps_slots", vars_states_o, pack8(exp_slots));
    for (int k = 0; k < 8; k++)
      check("store_mem_wrap", mem[9'h1FC + 9'(k)], 17'h0A0 + 17'(k));

    // both starts: load wins; starts during busy and during done are ignored
    do_load(9'h040, 1'b1, 1'b1, 0);
    check("both_load_vector", vars_states_o, pack8(exp_slots));

    // reset in cycle 4 of a load, then a clean load
    do_load(9'h010, 1'b0, 1'b0, 4);
    do_load(9'h010, 1'b0, 1'b0, 0);
    check("reload_vector", vars_states_o, pack8(exp_slots));

    // load then store back the echoed words
    do_load(9'h080, 1'b0, 1'b0, 0);
    echo = 1'b1;
    repeat (2) @(negedge clk);
    do_store(9'h080, pack8(exp_slots), 0);
    echo = 1'b0;
    for (int k = 0; k < 8; k++)
      check("roundtrip_mem", mem[9'h080 + 9'(k)], 17'h15000 + 17'(k * 'h123));
    if (donelog.size() >= 2)
      check("done_gap_ge_12", (donelog[donelog.size()-1] - donelog[donelog.size()-2]) >= 12, 1);
    else
      check("done_count", donelog.size(), 2);

    repeat (3) @(negedge clk);
    check("rd_queue_empty", rdq.size(), 0);
    check("wr_queue_empty", wrq.size(), 0);
    check("st_queue_empty", stq.size(), 0);
    check("done_queue_empty", doneq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vars_states_loader.md
# vars_states_loader

- Moves per-variable state words between the variable-state BRAM and the sat engine's variable-state load/update port.
- On a load command it reads NUM_VARS words from memory and writes them into the engine's var-state banks through the engine's `wr_states`/`vars_states_i`.
- On a store command it snapshots the engine's `vars_states_o` and writes NUM_VARS words back to memory.
- It sits between the BRAM and the engine, on the far side of the engine's load/update interface.

## Interface

Parameters:
- NUM_VARS, 8, variables handled per transfer; must equal the engine's NUM_VARS.
- WIDTH_VAR_STATES, 17, bits per variable state word (value plus level).
- ADDR_WIDTH, 9, BRAM address width; one BRAM word holds one variable state.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-low (all state clears at the rising clk edge where rst==0).
- start_load_i  in  1  load request; sampled only when busy_o==0.
- start_store_i  in  1  store request; sampled only when busy_o==0.
- base_addr_i  in  ADDR_WIDTH  address of variable 0; captured with the accepted start.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse at the end of every transfer.
- mem_rd_en_o  out  1  BRAM read strobe.
- mem_rd_addr_o  out  ADDR_WIDTH  BRAM read address.
- mem_rd_data_i  in  WIDTH_VAR_STATES  BRAM read data, valid exactly 1 cycle after mem_rd_en_o.
- mem_wr_en_o  out  1  BRAM write strobe.
- mem_wr_addr_o  out  ADDR_WIDTH  BRAM write address.
- mem_wr_data_o  out  WIDTH_VAR_STATES  BRAM write data.
- wr_states_o  out  NUM_VARS  per-variable write strobe to the engine (engine `wr_states`).
- vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS  state words to the engine (engine `vars_states_i`).
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS  state words from the engine (engine `vars_states_o`).

## Operation

Packing:
- Variable k occupies bits [WIDTH_VAR_STATES*(NUM_VARS-k)-1 -: WIDTH_VAR_STATES]; variable 0 is in the MSBs.
- Variable k's strobe is wr_states_o bit NUM_VARS-1-k.

FSM states:
- IDLE: start_load_i gives LOAD; otherwise start_store_i gives STORE. If both are high, load wins and the store request is dropped.
- LOAD: issues NUM_VARS reads on consecutive cycles, addresses base+0 .. base+NUM_VARS-1, then goes to LOAD_DRAIN.
- LOAD_DRAIN: 2 cycles, registering and writing the last returned words, then DONE.
- STORE: the snapshot of vars_states_i is taken at the accepting edge. Writes slot k to base+k on consecutive cycles, then DONE.
- DONE: done_o=1 for one cycle, then IDLE.

Data rules:
- Each returned read word is registered into its slot of vars_states_o.
- Slots of vars_states_o hold their values between transfers; store does not change them.
- Address arithmetic is modulo 2^ADDR_WIDTH: base+k wraps past the top address.
- Engine changes to vars_states_i during STORE do not affect the data written.

Control rules:
- busy_o is 1 in every state except IDLE, including the DONE cycle. A start asserted during done_o is ignored.
- Reset at any point, including mid-transfer: FSM returns to IDLE, no done pulse, the partially written engine/BRAM contents are left as they are.

Reset values: all outputs 0, including vars_states_o and both addresses.

## Timing

Cycle 0 is the cycle in which the start is sampled.

Load:
- mem_rd_en_o=1 in cycles 1..NUM_VARS, address base+(c-1).
- Variable k data arrives in cycle k+2 and is visible on vars_states_o from cycle k+3.
- done_o is in cycle NUM_VARS+3.

Store:
- mem_wr_en_o=1 in cycles 1..NUM_VARS, address base+(c-1), data = snapshot slot c-1.
- done_o is in cycle NUM_VARS+1.

Back-to-back transfers: the next start can be accepted at the earliest in the cycle after done_o.

## Configuration

Macro `VARS_LOADER_BURST_WR_EN` selects how the engine strobes are driven during a load:
- Undefined: wr_states_o is one-hot per variable. The bit for variable k is 1 in cycle k+3 only, with that slot already valid.
- Defined: wr_states_o stays 0 while the slots fill. All NUM_VARS bits are 1 together for one cycle, in cycle NUM_VARS+2, with the complete vector valid.
- Either way, done_o stays in cycle NUM_VARS+3 and store behaviour is unchanged.

## Test plan

All scenarios use NUM_VARS=8, WIDTH_VAR_STATES=17, ADDR_WIDTH=9.

1. Load with BRAM[0x10+k]=0x100+k and the macro undefined. Required: reads 0x10..0x17 in cycles 1..8; wr_states_o=8'h80>>k in cycle k+3 with slot k=0x100+k; done_o in cycle 11.
2. Same load with `VARS_LOADER_BURST_WR_EN` defined. Required: wr_states_o=0 through cycle 9; 8'hFF in cycle 10 with all slots correct; done_o in cycle 11.
3. Store from base 0x1FC with slot k=0x0A0+k, and the engine input changed in cycle 2. Required: writes to 0x1FC..0x1FF and then 0x000..0x003 carrying the cycle-0 snapshot; done_o in cycle 9.
4. start_load_i and start_store_i both high in IDLE. Required: load only, no BRAM writes. A second start during busy_o, including the done cycle, is ignored.
5. rst=0 in cycle 4 of a load. Required: next cycle has busy_o=0, all strobes 0, vars_states_o=0, no done_o. A new load then completes normally.
6. Load, then store to the same base with unchanged engine echo of the loaded words. Required: BRAM contents are identical afterwards, and the two done pulses are 12 cycles apart at minimum.
